// File: rtl/key_debounce_repeat.sv
// Push-button conditioner: two-flop synchroniser, debounce, and optional auto-repeat.
// Emits registered one-cycle step/release pulses and a debounced pressed level.
module key_debounce_repeat #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic aclr,
  input  logic key_n,
  input  logic repeat_en,
  output logic level,
  output logic step,
  output logic release_pulse
);

  localparam int unsigned MaxDr = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                    : REPEAT_DELAY;
  localparam int unsigned MaxCycles = (MaxDr > REPEAT_RATE) ? MaxDr : REPEAT_RATE;
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {
    StIdle        = 3'd0,
    StPressWait   = 3'd1,
    StHeldDelay   = 3'd2,
    StHeldRepeat  = 3'd3,
    StReleaseWait = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sync1_q, key_s_q;
  logic            level_q, level_d;
  logic            step_q, step_d;
  logic            rel_q, rel_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    step_d  = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      StIdle: begin
        level_d = 1'b0;
        if (!key_s_q) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (key_s_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StHeldDelay;
          cnt_d   = '0;
          step_d  = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeldDelay: begin
        if (key_s_q) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          cnt_d = '0;
        end else if (cnt_q == DelayLast) begin
          state_d = StHeldRepeat;
          cnt_d   = '0;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeldRepeat: begin
        if (key_s_q) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          state_d = StHeldDelay;
          cnt_d   = '0;
        end else if (cnt_q == RateLast) begin
          cnt_d  = '0;
          step_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReleaseWait: begin
        // A key that drops again before the debounce ends was bounce; restart the repeat delay.
        if (!key_s_q) begin
          state_d = StHeldDelay;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      sync1_q <= 1'b1;
      key_s_q <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      level_q <= 1'b0;
      step_q  <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= key_n;
      key_s_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      step_q  <= step_d;
      rel_q   <= rel_d;
    end
  end

  assign level         = level_q;
  assign step          = step_q;
  assign release_pulse = rel_q;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Bench for key_debounce_repeat: directed scenarios plus random key/repeat_en traffic,
// checked cycle by cycle against a run-length reference model.
module tb_key_debounce_repeat;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 3;

  logic clk = 1'b0;
  logic aclr;
  logic key_n;
  logic repeat_en;
  logic level;
  logic step;
  logic release_pulse;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  key_debounce_repeat #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk          (clk),
    .aclr         (aclr),
    .key_n        (key_n),
    .repeat_en    (repeat_en),
    .level        (level),
    .step         (step),
    .release_pulse(release_pulse)
  );

  // Model: key_s is key_n two samples late; press/release accepted when key_s has held the
  // new value for D+1 samples; repeat steps fall at held-enabled sample counts RD, RD+RR, ...
  logic m_d1, m_d2, m_prev, m_lvl, m_step, m_rel;
  int   m_run, m_hold;
  int   edge_n;
  int   step_edges[$];
  int   exp_q[$];

  task automatic model_reset();
    m_d1 = 1'b1; m_d2 = 1'b1; m_prev = 1'b1;
    m_run = 0; m_hold = 0;
    m_lvl = 1'b0; m_step = 1'b0; m_rel = 1'b0;
  endtask

  task automatic model_edge(input logic kn, input logic re);
    logic ks;
    ks = m_d2;
    m_d2 = m_d1;
    m_d1 = kn;
    m_step = 1'b0;
    m_rel  = 1'b0;
    if (ks == m_prev) m_run++;
    else m_run = 1;
    m_prev = ks;
    if (!m_lvl) begin
      if (!ks && m_run == int'(D) + 1) begin
        m_lvl = 1'b1; m_step = 1'b1; m_hold = 0;
      end
    end else if (ks) begin
      m_hold = 0;
      if (m_run == int'(D) + 1) begin
        m_lvl = 1'b0; m_rel = 1'b1;
      end
    end else if (m_run == 1 || !re) begin
      m_hold = 0;
    end else begin
      m_hold++;
      if (m_hold >= int'(RD) && (m_hold - int'(RD)) % int'(RR) == 0) m_step = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    check("level", level, m_lvl);
    check("step", step, m_step);
    check("release", release_pulse, m_rel);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(key_n, repeat_en);
    edge_n++;
    @(negedge clk);
    check_outs();
    if (step === 1'b1) step_edges.push_back(edge_n);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_scenario();
    edge_n = 0;
    step_edges.delete();
  endtask

  task automatic check_edges(input string tag);
    check_int({tag, "_count"}, step_edges.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < step_edges.size()) check_int({tag, "_edge"}, step_edges[i], exp_q[i]);
    end
  endtask

  // Asynchronous reset pulse driven away from the active edge.
  task automatic pulse_reset(input int cycles);
    #1 aclr = 1'b0;
    #1;
    model_reset();
    check("rst_level", level, 1'b0);
    check("rst_step", step, 1'b0);
    check("rst_release", release_pulse, 1'b0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_outs();
    end
    aclr = 1'b1;
  endtask

  initial begin
    aclr = 1'b0;
    key_n = 1'b1;
    repeat_en = 1'b0;
    model_reset();
    edge_n = 0;
    @(negedge clk);
    check_outs();
    pulse_reset(2);
    ticks(8);

    // Clean press, no repeat
    start_scenario();
    key_n = 1'b0;
    ticks(30);
    key_n = 1'b1;
    ticks(10);
    exp_q = '{7};
    check_edges("clean_press");

    // Short bounce rejected
    start_scenario();
    key_n = 1'b0;
    ticks(2);
    key_n = 1'b1;
    ticks(10);
    check_int("bounce_steps", step_edges.size(), 0);

    // Hold with auto-repeat
    start_scenario();
    repeat_en = 1'b1;
    key_n = 1'b0;
    ticks(30);
    exp_q = '{7, 17, 20, 23, 26, 29};
    check_edges("repeat");
    key_n = 1'b1;
    ticks(8);

    // Release bounce absorbed; repeat delay restarts
    start_scenario();
    key_n = 1'b0;
    ticks(12);
    key_n = 1'b1;
    ticks(2);
    key_n = 1'b0;
    ticks(20);
    exp_q = '{7, 27, 30, 33};
    check_edges("rel_bounce");
    key_n = 1'b1;
    ticks(8);

    // repeat_en toggled while repeating
    start_scenario();
    key_n = 1'b0;
    ticks(22);
    repeat_en = 1'b0;
    ticks(5);
    repeat_en = 1'b1;
    ticks(15);
    exp_q = '{7, 17, 20, 37, 40};
    check_edges("re_toggle");
    key_n = 1'b1;
    ticks(8);

    // Reset mid-repeat with key held: acts as a fresh press
    key_n = 1'b0;
    ticks(20);
    pulse_reset(1);
    start_scenario();
    ticks(12);
    exp_q = '{7};
    check_edges("reset_held");
    key_n = 1'b1;
    ticks(8);

    // Random traffic
    for (int seg = 0; seg < 400; seg++) begin
      key_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) repeat_en = ~repeat_en;
      if ($urandom_range(0, 59) == 0) pulse_reset($urandom_range(1, 2));
      if ($urandom_range(0, 4) == 0) ticks($urandom_range(10, 30));
      else ticks($urandom_range(1, 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_debounce_repeat.md
Name: key_debounce_repeat

Overview:
- Upstream conditioning stage for the board's push-button-driven counters.
- Synchronises a raw active-low KEY input, rejects contact bounce, and emits single-cycle step pulses.
- Auto-repeat is optional: holding the key produces more pulses after an initial delay, then at a fixed rate.
- The step output drives the enable or clock-enable of the BCD counter chain; level and release outputs drive LEDs and other logic.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clocks the synchronised key must be stable before a press or release is accepted (20 ms at 50 MHz); must be >= 1.
- REPEAT_DELAY, 25000000, clocks from the accepted press to the first auto-repeat step; must be >= 1.
- REPEAT_RATE, 5000000, clocks between subsequent auto-repeat steps; must be >= 1.

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- aclr  input  1  asynchronous reset, active-low
- key_n  input  1  raw board key, active-low, asynchronous to clk
- repeat_en  input  1  1 = auto-repeat enabled while held
- level  output  1  debounced key state, 1 = pressed
- step  output  1  one-cycle pulse on accepted press and on each auto-repeat
- release  output  1  one-cycle pulse on accepted release

Behaviour:
- Reset (aclr=0, asynchronous): both synchroniser flops go to 1; state goes to IDLE; cnt goes to 0; level, step and release go to 0.
- Synchroniser: two flops; key_s is key_n delayed by 2 clocks.
- cnt is a single shared counter, width clogb2 of the maximum of the three parameters. All outputs are registered.
- step and release are high for exactly one cycle: the cycle after the edge that sets them. They are 0 in every other cycle.
- State IDLE (level=0):
  - key_s=0 -> PRESS_WAIT, cnt<=0.
- State PRESS_WAIT (level=0):
  - key_s=1 -> IDLE; bounce is rejected with no output.
  - else if cnt==DEBOUNCE_CYCLES-1 -> HELD_DELAY, cnt<=0, step<=1, level<=1.
  - else cnt<=cnt+1.
- State HELD_DELAY (level=1):
  - key_s=1 -> RELEASE_WAIT, cnt<=0.
  - else if repeat_en=0 -> cnt<=0 (hold).
  - else if cnt==REPEAT_DELAY-1 -> HELD_REPEAT, cnt<=0, step<=1.
  - else cnt<=cnt+1.
- State HELD_REPEAT (level=1):
  - key_s=1 -> RELEASE_WAIT, cnt<=0.
  - else if repeat_en=0 -> HELD_DELAY, cnt<=0, no step.
  - else if cnt==REPEAT_RATE-1 -> cnt<=0, step<=1.
  - else cnt<=cnt+1.
- State RELEASE_WAIT (level=1):
  - key_s=0 -> HELD_DELAY, cnt<=0, no step; release bounce is absorbed and the repeat delay restarts.
  - else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt<=0, level<=0, release<=1.
  - else cnt<=cnt+1.
- Press latency: key_n first sampled low at edge 1 with a clean press -> step high after edge DEBOUNCE_CYCLES+3. That is 2 edges of synchroniser, 1 edge for IDLE->PRESS_WAIT, and DEBOUNCE_CYCLES edges of counting.
- Priority: a key_s change outranks any counter terminal in the same cycle. A release coinciding with a repeat deadline gives no step.
- repeat_en is sampled every cycle. Toggling it never creates a step.
- Key held through reset deassertion: treated as a new press, producing one step after the full debounce.
- Reset mid-operation (any state): outputs clear immediately and no pending pulse survives.
- DEBOUNCE_CYCLES=1: PRESS_WAIT and RELEASE_WAIT each last one cycle; the same rules apply.
- Undefined state encodings recover to IDLE with outputs 0.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3; edge 1 is the first edge sampling key_n=0.
- Clean press, repeat_en=0, key_n low for 30 edges then high: step=1 only after edge 7; level=1 from edge 7. After release, release=1 for one cycle and level=0 on the same edge; no further step.
- Bounce, key_n low for 2 edges then high: step, level and release stay 0 throughout; state returns to IDLE.
- Hold with repeat_en=1 for 30 edges: step pulses after edges 7, 17, 20, 23, 26, 29; level stays 1.
- Release bounce (key_n high 2 edges, low again, then hold): release never pulses, level stays 1, no extra step. With repeat_en=1, the next step comes 10 edges after re-entering HELD_DELAY.
- repeat_en dropped to 0 during HELD_REPEAT, then raised: no step on either toggle; the next step comes 10 edges after re-enable.
- aclr pulsed low mid-HELD_REPEAT with key held: level and step are 0 immediately. After aclr rises, the first step comes DEBOUNCE_CYCLES+3 edges later.
